pwm_sample_feeder: RTL

Upstream stage of the PWM audio DAC. Accepts signed 12-bit audio samples over a valid/ready stream, buffers them in a small FIFO, and presents one offset-binary `duty_cycle` value per PWM period, updated exactly on period boundaries. It runs entirely in the PWM clock domain and drives the DAC's `duty_cycle` input directly. Underruns are counted so software can detect starvation.

---
 rtl/pwm_sample_feeder_if.sv | 9 +
 rtl/pwm_sample_feeder.sv | 107 ++++++++++
 2 files changed

// File: rtl/pwm_sample_feeder_if.sv
// pwm_sample_feeder_if: valid/ready stream carrying signed 12-bit audio samples
interface pwm_sample_feeder_if;
    logic [11:0] in_sample;
    logic        in_valid;
    logic        in_ready;

    modport master (output in_sample, output in_valid, input in_ready);
    modport slave  (input in_sample, input in_valid, output in_ready);
endinterface

// File: rtl/pwm_sample_feeder.sv
// pwm_sample_feeder: buffers audio samples and hands one offset-binary duty value to the PWM DAC per period
module pwm_sample_feeder #(
    parameter int          DEPTH     = 4,
    parameter int          PERIOD    = 4095,
    parameter logic [11:0] IDLE_CODE = 12'h800
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_enable,
    input  logic                    i_flush,
    pwm_sample_feeder_if.slave      i_stream,
    output logic [11:0]             o_duty_cycle,
    output logic                    o_period_tick,
    output logic [$clog2(DEPTH):0]  o_fifo_count,
    output logic [15:0]             o_underrun_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(PERIOD);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(PERIOD - 1);

    logic [11:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_pcnt;
    logic [11:0]   r_duty_cycle;
    logic          r_period_tick;
    logic [15:0]   r_underrun_count;

    logic          w_ready;
    logic          w_push;
    logic          w_boundary;
    logic          w_pop;
    logic          w_underrun;

    // Flush overrides both FIFO ports; a boundary that cannot pop counts as an underrun
    always_comb begin
        w_ready    = r_count < FULL;
        w_push     = i_stream.in_valid && w_ready && !i_flush;
        w_boundary = i_enable && (r_pcnt == LAST);
        w_pop      = w_boundary && (r_count != '0) && !i_flush;
        w_underrun = w_boundary && !w_pop;
    end

    assign i_stream.in_ready = w_ready;
    assign o_duty_cycle      = r_duty_cycle;
    assign o_period_tick     = r_period_tick;
    assign o_fifo_count      = r_count;
    assign o_underrun_count  = r_underrun_count;

    // Sample storage, converted from two's complement to offset binary on the way in
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {~i_stream.in_sample[11], i_stream.in_sample[10:0]};
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Period counter runs only while enabled so re-enable always starts a fresh period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt        <= '0;
            r_period_tick <= 1'b0;
        end else begin
            r_pcnt        <= (i_enable && !w_boundary) ? r_pcnt + PW'(1) : '0;
            r_period_tick <= w_boundary;
        end
    end

    // Duty value changes only on a boundary pop or when playback is disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_cycle <= IDLE_CODE;
        end else if (!i_enable) begin
            r_duty_cycle <= IDLE_CODE;
        end else if (w_pop) begin
            r_duty_cycle <= r_mem[r_rptr];
        end
    end

    // Saturating count of starved periods, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underrun_count <= '0;
        end else if (w_underrun && (r_underrun_count != 16'hFFFF)) begin
            r_underrun_count <= r_underrun_count + 16'd1;
        end
    end
endmodule
